// File: rtl/projectile_engine.sv
// projectile_engine: N_OBJ-channel projectile tracker with a shared gravity clock,
// per-frame sequential position sweep, launch allocation, and cut/exit reporting.
module projectile_engine #(
    parameter int unsigned N_OBJ       = 4,
    parameter int unsigned X_W         = 11,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned V_W         = 6,
    parameter int unsigned X_MAX       = 1024,
    parameter int unsigned Y_MAX       = 768,
    parameter int unsigned LAUNCH_Y    = 700,
    parameter int unsigned GRAV_PERIOD = 10,
    parameter int unsigned GRAV_STEP   = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   frame_tick_in,
    input  logic                   launch_valid_in,
    output logic                   launch_ready_out,
    input  logic [X_W-1:0]         launch_x_in,
    input  logic [V_W-1:0]         launch_vx_in,
    input  logic [V_W-1:0]         launch_vy_in,
    input  logic                   kill_valid_in,
    input  logic [$clog2(N_OBJ)-1:0] kill_idx_in,
    output logic [N_OBJ*X_W-1:0]   obj_x_out,
    output logic [N_OBJ*Y_W-1:0]   obj_y_out,
    output logic [N_OBJ-1:0]       obj_active_out,
    output logic                   exit_valid_out,
    output logic [$clog2(N_OBJ)-1:0] exit_idx_out,
    output logic                   exit_cut_out,
    output logic                   busy_out
);

    localparam int unsigned IDX_W = $clog2(N_OBJ);
    // Signed position math: one guard bit above max(X_W,Y_W)+1
    localparam int unsigned P_W   = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int unsigned S_W   = V_W + 2;
    localparam int unsigned GC_W  = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;

    localparam logic signed [P_W-1:0]  NX_LIM = P_W'(X_MAX);
    localparam logic signed [P_W-1:0]  NY_LIM = P_W'(Y_MAX);
    localparam logic signed [S_W-1:0]  G_STEP = S_W'(GRAV_STEP);
    localparam logic signed [S_W-1:0]  V_SAT  = S_W'(2 ** (V_W - 1) - 1);
    localparam logic [GC_W-1:0]        GC_TOP = GC_W'(GRAV_PERIOD - 1);

    // Channel state
    logic [N_OBJ-1:0]         active_q, kill_pend_q;
    logic [X_W-1:0]           x_q  [N_OBJ];
    logic [Y_W-1:0]           y_q  [N_OBJ];
    logic signed [V_W-1:0]    vx_q [N_OBJ];
    logic signed [V_W-1:0]    vy_q [N_OBJ];

    // Next-state copies
    logic [N_OBJ-1:0]         act_n, kp_n;
    logic [X_W-1:0]           x_n  [N_OBJ];
    logic [Y_W-1:0]           y_n  [N_OBJ];
    logic signed [V_W-1:0]    vx_n [N_OBJ];
    logic signed [V_W-1:0]    vy_n [N_OBJ];

    // Sweep / gravity control
    logic                     busy_q, grav_frame_q;
    logic [IDX_W-1:0]         sweep_idx_q;
    logic [GC_W-1:0]          grav_cnt_q;

    logic                     ex_valid_n, ex_cut_n;
    logic [IDX_W-1:0]         ex_idx_n;

    logic                     free_found, retire_found;
    logic [IDX_W-1:0]         free_idx, retire_idx;

    logic signed [P_W-1:0]    nx, ny;
    logic signed [S_W-1:0]    vy_sum;
    logic                     out_of_range;
    logic                     launch_fire;

    // Lowest-index free channel and lowest-index pending kill
    always_comb begin
        free_found   = 1'b0;
        free_idx     = '0;
        retire_found = 1'b0;
        retire_idx   = '0;
        for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (kill_pend_q[i]) begin
                retire_found = 1'b1;
                retire_idx   = IDX_W'(i);
            end
        end
    end

    assign launch_ready_out = !busy_q && free_found;
    assign launch_fire      = launch_valid_in && launch_ready_out;

    // Candidate motion for the channel currently addressed by the sweep
    always_comb begin
        nx           = $signed(P_W'(x_q[sweep_idx_q])) + P_W'(vx_q[sweep_idx_q]);
        ny           = $signed(P_W'(y_q[sweep_idx_q])) + P_W'(vy_q[sweep_idx_q]);
        vy_sum       = S_W'(vy_q[sweep_idx_q]) + G_STEP;
        out_of_range = nx[P_W-1] || (nx >= NX_LIM) || ny[P_W-1] || (ny >= NY_LIM);
    end

    // Channel next state: sweep update, kill capture, retirement, launch
    always_comb begin
        act_n      = active_q;
        kp_n       = kill_pend_q;
        x_n        = x_q;
        y_n        = y_q;
        vx_n       = vx_q;
        vy_n       = vy_q;
        ex_valid_n = 1'b0;
        ex_idx_n   = '0;
        ex_cut_n   = 1'b0;

        if (busy_q && active_q[sweep_idx_q] && !kill_pend_q[sweep_idx_q]) begin
            if (out_of_range) begin
                act_n[sweep_idx_q] = 1'b0;
                ex_valid_n         = 1'b1;
                ex_idx_n           = sweep_idx_q;
            end else begin
                x_n[sweep_idx_q] = nx[X_W-1:0];
                y_n[sweep_idx_q] = ny[Y_W-1:0];
                if (grav_frame_q) begin
                    vy_n[sweep_idx_q] = (vy_sum > V_SAT) ? V_W'(V_SAT) : V_W'(vy_sum);
                end
            end
        end

        // A kill that coincides with its channel's exit is dropped
        if (kill_valid_in && active_q[kill_idx_in] && act_n[kill_idx_in]) begin
            kp_n[kill_idx_in] = 1'b1;
        end

        if (!busy_q && retire_found) begin
            act_n[retire_idx] = 1'b0;
            kp_n[retire_idx]  = 1'b0;
            ex_valid_n        = 1'b1;
            ex_idx_n          = retire_idx;
            ex_cut_n          = 1'b1;
        end

        if (launch_fire) begin
            act_n[free_idx] = 1'b1;
            kp_n[free_idx]  = 1'b0;
            x_n[free_idx]   = launch_x_in;
            y_n[free_idx]   = Y_W'(LAUNCH_Y);
            vx_n[free_idx]  = launch_vx_in;
            vy_n[free_idx]  = launch_vy_in;
        end
    end

    // Channel state and exit event registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            active_q    <= '0;
            kill_pend_q <= '0;
            for (int i = 0; i < int'(N_OBJ); i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            exit_valid_out <= 1'b0;
            exit_idx_out   <= '0;
            exit_cut_out   <= 1'b0;
        end else begin
            active_q       <= act_n;
            kill_pend_q    <= kp_n;
            x_q            <= x_n;
            y_q            <= y_n;
            vx_q           <= vx_n;
            vy_q           <= vy_n;
            exit_valid_out <= ex_valid_n;
            exit_idx_out   <= ex_idx_n;
            exit_cut_out   <= ex_cut_n;
        end
    end

    // Sweep sequencing and gravity counter; ticks during a sweep are ignored
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q       <= 1'b0;
            sweep_idx_q  <= '0;
            grav_frame_q <= 1'b0;
            grav_cnt_q   <= '0;
        end else if (!busy_q) begin
            if (frame_tick_in) begin
                busy_q       <= 1'b1;
                sweep_idx_q  <= '0;
                grav_frame_q <= (grav_cnt_q == GC_TOP);
                grav_cnt_q   <= (grav_cnt_q == GC_TOP) ? '0 : grav_cnt_q + GC_W'(1);
            end
        end else if (sweep_idx_q == IDX_W'(N_OBJ - 1)) begin
            busy_q <= 1'b0;
        end else begin
            sweep_idx_q <= sweep_idx_q + IDX_W'(1);
        end
    end

    // Packed position outputs, channel 0 in the LSBs
    for (genvar g = 0; g < int'(N_OBJ); g++) begin : g_pack
        assign obj_x_out[g*X_W +: X_W] = x_q[g];
        assign obj_y_out[g*Y_W +: Y_W] = y_q[g];
    end

    assign obj_active_out = active_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_projectile_engine.sv
// Self-checking bench for projectile_engine: directed scenarios plus an exit-event scoreboard.
module tb_projectile_engine;

    localparam int unsigned N_OBJ = 4;
    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned V_W   = 6;
    localparam int unsigned IDX_W = 2;

    typedef struct {
        int idx;
        int cut;
    } exit_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic                 rst_n_in;
    logic                 frame_tick_in, launch_valid_in, launch_ready_out;
    logic [X_W-1:0]       launch_x_in;
    logic [V_W-1:0]       launch_vx_in, launch_vy_in;
    logic                 kill_valid_in;
    logic [IDX_W-1:0]     kill_idx_in;
    logic [N_OBJ*X_W-1:0] obj_x_out;
    logic [N_OBJ*Y_W-1:0] obj_y_out;
    logic [N_OBJ-1:0]     obj_active_out;
    logic                 exit_valid_out, exit_cut_out, busy_out;
    logic [IDX_W-1:0]     exit_idx_out;

    logic                 g_frame_tick, g_launch_valid, g_launch_ready;
    logic [X_W-1:0]       g_launch_x;
    logic [V_W-1:0]       g_launch_vx, g_launch_vy;
    logic [N_OBJ*X_W-1:0] g_obj_x;
    logic [N_OBJ*Y_W-1:0] g_obj_y;
    logic [N_OBJ-1:0]     g_obj_active;
    logic                 g_exit_valid, g_exit_cut, g_busy;
    logic [IDX_W-1:0]     g_exit_idx;

    int    checks = 0;
    int    errors = 0;
    exit_t exp_q[$];

    projectile_engine u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_tick_in(frame_tick_in),
        .launch_valid_in(launch_valid_in), .launch_ready_out(launch_ready_out),
        .launch_x_in(launch_x_in), .launch_vx_in(launch_vx_in), .launch_vy_in(launch_vy_in),
        .kill_valid_in(kill_valid_in), .kill_idx_in(kill_idx_in),
        .obj_x_out(obj_x_out), .obj_y_out(obj_y_out), .obj_active_out(obj_active_out),
        .exit_valid_out(exit_valid_out), .exit_idx_out(exit_idx_out),
        .exit_cut_out(exit_cut_out), .busy_out(busy_out)
    );

    projectile_engine #(.GRAV_PERIOD(2), .GRAV_STEP(2)) u_grav (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_tick_in(g_frame_tick),
        .launch_valid_in(g_launch_valid), .launch_ready_out(g_launch_ready),
        .launch_x_in(g_launch_x), .launch_vx_in(g_launch_vx), .launch_vy_in(g_launch_vy),
        .kill_valid_in(1'b0), .kill_idx_in(2'd0),
        .obj_x_out(g_obj_x), .obj_y_out(g_obj_y), .obj_active_out(g_obj_active),
        .exit_valid_out(g_exit_valid), .exit_idx_out(g_exit_idx),
        .exit_cut_out(g_exit_cut), .busy_out(g_busy)
    );

    function automatic int ch_x(input logic [N_OBJ*X_W-1:0] v, input int i);
        return int'(v[i*X_W +: X_W]);
    endfunction

    function automatic int ch_y(input logic [N_OBJ*Y_W-1:0] v, input int i);
        return int'(v[i*Y_W +: Y_W]);
    endfunction

    task automatic apply_reset();
        rst_n_in        = 1'b0;
        frame_tick_in   = 1'b0;
        launch_valid_in = 1'b0;
        kill_valid_in   = 1'b0;
        g_frame_tick    = 1'b0;
        g_launch_valid  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic launch(input int x, input int vx, input int vy);
        launch_valid_in = 1'b1;
        launch_x_in     = X_W'(x);
        launch_vx_in    = V_W'(vx);
        launch_vy_in    = V_W'(vy);
        @(posedge clk_in); #1;
        launch_valid_in = 1'b0;
    endtask

    task automatic frame();
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1;
        frame_tick_in = 1'b0;
        repeat (N_OBJ) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b1; frame_tick_in = 1'b0; launch_valid_in = 1'b0; kill_valid_in = 1'b0;
        g_frame_tick = 1'b0; g_launch_valid = 1'b0;
        launch_x_in = '0; launch_vx_in = '0; launch_vy_in = '0; kill_idx_in = '0;
        g_launch_x = '0; g_launch_vx = '0; g_launch_vy = '0;
        #2 rst_n_in = 1'b0;
        #2;
        checks++;
        if (obj_active_out !== '0 || busy_out !== 1'b0 || exit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: active=%b busy=%b exit=%b, required 0/0/0",
                     obj_active_out, busy_out, exit_valid_out);
        end
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        launch(10, 1, -1);
        launch(20, 1, -1);
        launch(30, 1, -1);
        checks++;
        if (obj_active_out !== 4'b0111) begin
            errors++;
            $display("FAIL reset_setup_active: got %b, required 0111", obj_active_out);
        end
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1 frame_tick_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_midsweep_busy: got %b, required 1", busy_out);
        end
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (obj_x_out !== '0 || obj_y_out !== '0 || obj_active_out !== '0 ||
            busy_out !== 1'b0 || exit_valid_out !== 1'b0 || exit_idx_out !== '0 ||
            exit_cut_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: x=%h y=%h act=%b busy=%b exit=%b, required all 0",
                     obj_x_out, obj_y_out, obj_active_out, busy_out, exit_valid_out);
        end
        @(posedge clk_in); #1 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (launch_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", launch_ready_out);
        end
    endtask

    task automatic test_single_launch();
        apply_reset();
        launch(100, 3, -10);
        checks++;
        if (obj_active_out !== 4'b0001 || ch_x(obj_x_out, 0) != 100 || ch_y(obj_y_out, 0) != 700) begin
            errors++;
            $display("FAIL launch_visible: act=%b x=%0d y=%0d, required 0001/100/700",
                     obj_active_out, ch_x(obj_x_out, 0), ch_y(obj_y_out, 0));
        end
        repeat (5) frame();
        checks++;
        if (ch_x(obj_x_out, 0) != 115 || ch_y(obj_y_out, 0) != 650 || obj_active_out !== 4'b0001) begin
            errors++;
            $display("FAIL five_frames: x=%0d y=%0d act=%b, required 115/650/0001",
                     ch_x(obj_x_out, 0), ch_y(obj_y_out, 0), obj_active_out);
        end
    endtask

    task automatic test_gravity();
        int exp_y[7] = '{696, 692, 690, 688, 688, 688, 690};
        apply_reset();
        g_launch_valid = 1'b1;
        g_launch_x     = X_W'(500);
        g_launch_vx    = V_W'(0);
        g_launch_vy    = V_W'(-4);
        @(posedge clk_in); #1 g_launch_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            g_frame_tick = 1'b1;
            @(posedge clk_in); #1 g_frame_tick = 1'b0;
            repeat (N_OBJ) @(posedge clk_in);
            #1;
            checks++;
            if (ch_y(g_obj_y, 0) != exp_y[k]) begin
                errors++;
                $display("FAIL gravity_y[%0d]: got %0d, required %0d", k, ch_y(g_obj_y, 0), exp_y[k]);
            end
        end
    endtask

    task automatic test_edge_exit();
        apply_reset();
        launch(1020, 5, 0);
        exp_q.push_back(exit_t'{0, 0});
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1 frame_tick_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL edge_exit_pulse: got %b, required 1", exit_valid_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b0 || obj_active_out[0] !== 1'b0 || ch_x(obj_x_out, 0) != 1020) begin
            errors++;
            $display("FAIL edge_exit_after: exit=%b act0=%b x=%0d, required 0/0/1020",
                     exit_valid_out, obj_active_out[0], ch_x(obj_x_out, 0));
        end
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL edge_exit_seen: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_full_alloc();
        logic [N_OBJ*X_W-1:0] exp_x;
        apply_reset();
        for (int k = 0; k < 4; k++) launch(100 * (k + 1), 1, 0);
        exp_x = {11'd400, 11'd300, 11'd200, 11'd100};
        checks++;
        if (obj_active_out !== 4'b1111 || launch_ready_out !== 1'b0 || obj_x_out !== exp_x) begin
            errors++;
            $display("FAIL full_alloc: act=%b ready=%b x=%h, required 1111/0/%h",
                     obj_active_out, launch_ready_out, obj_x_out, exp_x);
        end
        exp_q.push_back(exit_t'{2, 1});
        kill_valid_in = 1'b1;
        kill_idx_in   = 2'd2;
        @(posedge clk_in); #1 kill_valid_in = 1'b0;
        checks++;
        if (exit_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL kill_pending_no_exit: got %b, required 0", exit_valid_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b1 || obj_active_out !== 4'b1011 || launch_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL kill_retire: exit=%b act=%b ready=%b, required 1/1011/1",
                     exit_valid_out, obj_active_out, launch_ready_out);
        end
        launch(555, 1, 0);
        checks++;
        if (obj_active_out !== 4'b1111 || ch_x(obj_x_out, 2) != 555) begin
            errors++;
            $display("FAIL relaunch_slot: act=%b x2=%0d, required 1111/555",
                     obj_active_out, ch_x(obj_x_out, 2));
        end
    endtask

    task automatic test_kill_sweep();
        exp_q.push_back(exit_t'{1, 1});
        exp_q.push_back(exit_t'{3, 1});
        frame_tick_in = 1'b1;
        @(posedge clk_in); #1 frame_tick_in = 1'b0;
        kill_valid_in = 1'b1;
        kill_idx_in   = 2'd1;
        for (int c = 0; c < int'(N_OBJ); c++) begin
            @(posedge clk_in); #1;
            if (c == 0) kill_idx_in = 2'd3;
            if (c == 1) kill_valid_in = 1'b0;
            checks++;
            if (exit_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL no_exit_in_sweep[%0d]: got %b, required 0", c, exit_valid_out);
            end
        end
        checks++;
        if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done_busy: got %b, required 0", busy_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b1 || exit_idx_out !== 2'd1 || exit_cut_out !== 1'b1) begin
            errors++;
            $display("FAIL kill_exit_first: v=%b idx=%0d cut=%b, required 1/1/1",
                     exit_valid_out, exit_idx_out, exit_cut_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b1 || exit_idx_out !== 2'd3 || exit_cut_out !== 1'b1) begin
            errors++;
            $display("FAIL kill_exit_second: v=%b idx=%0d cut=%b, required 1/3/1",
                     exit_valid_out, exit_idx_out, exit_cut_out);
        end
        @(posedge clk_in); #1;
        checks++;
        if (exit_valid_out !== 1'b0 || obj_active_out !== 4'b0101) begin
            errors++;
            $display("FAIL kill_exit_end: v=%b act=%b, required 0/0101", exit_valid_out, obj_active_out);
        end
        checks++;
        if (ch_x(obj_x_out, 0) != 101 || ch_x(obj_x_out, 1) != 200 ||
            ch_x(obj_x_out, 2) != 556 || ch_x(obj_x_out, 3) != 400) begin
            errors++;
            $display("FAIL kill_sweep_positions: x0=%0d x1=%0d x2=%0d x3=%0d, required 101/200/556/400",
                     ch_x(obj_x_out, 0), ch_x(obj_x_out, 1), ch_x(obj_x_out, 2), ch_x(obj_x_out, 3));
        end
    endtask

    initial begin
        fork
            forever begin : exit_monitor
                exit_t e;
                @(negedge clk_in);
                if (exit_valid_out === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL exit_unexpected: idx=%0d cut=%b, required no exit",
                                 exit_idx_out, exit_cut_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(exit_idx_out) != e.idx || int'(exit_cut_out) != e.cut) begin
                            errors++;
                            $display("FAIL exit_event: idx=%0d cut=%0d, required idx=%0d cut=%0d",
                                     exit_idx_out, exit_cut_out, e.idx, e.cut);
                        end
                    end
                end
                if (g_exit_valid === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL grav_exit_unexpected: idx=%0d, required no exit", g_exit_idx);
                end
            end
        join_none

        test_reset();
        test_single_launch();
        test_gravity();
        test_edge_exit();
        test_full_alloc();
        test_kill_sweep();

        repeat (2) @(posedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
